// File: rtl/ifu_pc_gen_pkg.sv
// Shared types and defaults for the instruction-fetch PC generator.
package ifu_pc_gen_pkg;

  localparam int unsigned REG_BUS_WIDTH = 32;

  typedef logic [REG_BUS_WIDTH-1:0] reg_bus_t;

  localparam reg_bus_t PC_STEP_DEF      = 32'd4;
  localparam reg_bus_t RESET_VECTOR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    IFU_BOOT = 2'b00,
    IFU_RUN  = 2'b01,
    IFU_HOLD = 2'b10
  } ifu_state_e;

  function automatic logic is_aligned(input reg_bus_t addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ifu_pc_gen_if.sv
// Redirect/fetch signal bundle around the PC generator.
interface ifu_pc_gen_if;
  import ifu_pc_gen_pkg::*;

  logic [5:0] stall;
  logic [5:0] flush;
  logic       jump_req;
  reg_bus_t   jump_addr;
  logic       trap_req;
  reg_bus_t   trap_addr;
  logic       ce;
  reg_bus_t   pc;
  logic       jump_misalign;
  reg_bus_t   misalign_addr;

  // master: ctrl/EXU side that requests redirects and consumes the fetch address
  modport master (
    output stall, flush, jump_req, jump_addr, trap_req, trap_addr,
    input  ce, pc, jump_misalign, misalign_addr
  );

  modport slave (
    input  stall, flush, jump_req, jump_addr, trap_req, trap_addr,
    output ce, pc, jump_misalign, misalign_addr
  );

endinterface

// File: rtl/ifu_pc_gen.sv
// Instruction-fetch PC generator: sequential step, jump/trap redirect,
// stall hold with a pending redirect, and misaligned-jump reporting.
module ifu_pc_gen
  import ifu_pc_gen_pkg::*;
#(
  parameter reg_bus_t RESET_VECTOR = RESET_VECTOR_DEF,
  parameter reg_bus_t PC_STEP      = PC_STEP_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] stall_i,
  input  logic [5:0] flush_i,
  input  logic       jump_req_i,
  input  reg_bus_t   jump_addr_i,
  input  logic       trap_req_i,
  input  reg_bus_t   trap_addr_i,
  output logic       ce_o,
  output reg_bus_t   pc_o,
  output logic       jump_misalign_o,
  output reg_bus_t   misalign_addr_o
);

  ifu_state_e state_q, state_d;
  logic       ce_q, ce_d;
  reg_bus_t   pc_q, pc_d;
  logic       mis_q, mis_d;
  reg_bus_t   mis_addr_q, mis_addr_d;
  logic       pend_valid_q, pend_valid_d;
  reg_bus_t   pend_addr_q, pend_addr_d;

  logic stall_f;
  logic flush_f;
  logic jump_ok;
  logic jump_bad;

  // Only the fetch-stage bits of the stall/flush vectors matter here.
  logic unused_vec;
  assign unused_vec = ^{stall_i[5:1], flush_i[5:1]};

  assign stall_f  = stall_i[0];
  assign flush_f  = flush_i[0];
  assign jump_ok  = jump_req_i &&  is_aligned(jump_addr_i);
  assign jump_bad = jump_req_i && !is_aligned(jump_addr_i);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IFU_BOOT;
      ce_q         <= 1'b0;
      pc_q         <= RESET_VECTOR;
      mis_q        <= 1'b0;
      mis_addr_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      ce_q         <= ce_d;
      pc_q         <= pc_d;
      mis_q        <= mis_d;
      mis_addr_q   <= mis_addr_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ce_d         = ce_q;
    pc_d         = pc_q;
    mis_d        = 1'b0;
    mis_addr_d   = mis_addr_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;

    unique case (state_q)
      IFU_BOOT: begin
        ce_d    = 1'b1;
        pc_d    = RESET_VECTOR;
        state_d = IFU_RUN;
      end

      IFU_RUN, IFU_HOLD: begin
        if (trap_req_i) begin
          pc_d         = trap_addr_i;
          pend_valid_d = 1'b0;
          state_d      = IFU_RUN;
        end else if (jump_ok && flush_f) begin
          pc_d         = jump_addr_i;
          pend_valid_d = 1'b0;
          state_d      = IFU_RUN;
        end else if (jump_ok && stall_f) begin
          pend_addr_d  = jump_addr_i;
          pend_valid_d = 1'b1;
          state_d      = IFU_HOLD;
        end else if (jump_ok) begin
          pc_d         = jump_addr_i;
          pend_valid_d = 1'b0;
          state_d      = IFU_RUN;
        end else begin
          // Misaligned target: report it, keep fetching along the current path.
          if (jump_bad) begin
            mis_d      = 1'b1;
            mis_addr_d = jump_addr_i;
          end
          if (pend_valid_q && (flush_f || !stall_f)) begin
            pc_d         = pend_addr_q;
            pend_valid_d = 1'b0;
            state_d      = IFU_RUN;
          end else if (!stall_f) begin
            pc_d = pc_q + PC_STEP;
          end
        end
      end

      default: state_d = IFU_BOOT;
    endcase
  end

  assign ce_o            = ce_q;
  assign pc_o            = pc_q;
  assign jump_misalign_o = mis_q;
  assign misalign_addr_o = mis_addr_q;

endmodule

// File: tb/tb_ifu_pc_gen.sv
// Scenario bench for ifu_pc_gen: per-cycle stimulus tables, expected fetch
// outputs queued at drive time and compared one cycle later.
module tb_ifu_pc_gen;
  import ifu_pc_gen_pkg::*;

  typedef struct {
    logic       rst;
    logic [5:0] stall;
    logic [5:0] flush;
    logic       jr;
    reg_bus_t   ja;
    logic       tr;
    reg_bus_t   ta;
    reg_bus_t   pc;
    logic       ce;
    logic       mis;
    reg_bus_t   ma;
    int         st;
    int         pv;
  } stim_t;

  typedef struct {
    reg_bus_t pc;
    logic     ce;
    logic     mis;
    reg_bus_t ma;
    int       st;
    int       pv;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  exp_t sb[$];

  ifu_pc_gen_if bus();

  ifu_pc_gen #(.RESET_VECTOR(32'h0000_0000), .PC_STEP(32'd4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (bus.stall),
    .flush_i        (bus.flush),
    .jump_req_i     (bus.jump_req),
    .jump_addr_i    (bus.jump_addr),
    .trap_req_i     (bus.trap_req),
    .trap_addr_i    (bus.trap_addr),
    .ce_o           (bus.ce),
    .pc_o           (bus.pc),
    .jump_misalign_o(bus.jump_misalign),
    .misalign_addr_o(bus.misalign_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input stim_t s);
    exp_t e;
    @(negedge clk);
    rst_n         = s.rst;
    bus.stall     = s.stall;
    bus.flush     = s.flush;
    bus.jump_req  = s.jr;
    bus.jump_addr = s.ja;
    bus.trap_req  = s.tr;
    bus.trap_addr = s.ta;
    e.pc = s.pc; e.ce = s.ce; e.mis = s.mis; e.ma = s.ma; e.st = s.st; e.pv = s.pv;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t t[6];
    exp_t  e;
    t = '{
      '{0, 6'h00, 6'h00, 0, 32'h0, 0, 32'h0, 32'h0,  0, 0, 32'h0, 0, 0},
      '{1, 6'h00, 6'h00, 0, 32'h0, 0, 32'h0, 32'h0,  1, 0, 32'h0, 1, 0},
      '{1, 6'h00, 6'h00, 0, 32'h0, 0, 32'h0, 32'h4,  1, 0, 32'h0, -1, -1},
      '{1, 6'h00, 6'h00, 0, 32'h0, 0, 32'h0, 32'h8,  1, 0, 32'h0, -1, -1},
      '{1, 6'h00, 6'h00, 0, 32'h0, 0, 32'h0, 32'hC,  1, 0, 32'h0, -1, -1},
      '{1, 6'h00, 6'h00, 0, 32'h0, 0, 32'h0, 32'h10, 1, 0, 32'h0, 1, 0}
    };
    foreach (t[i]) begin
      drive(t[i]);
      n_assert++;
      if (sb.size() == 0) begin
        n_fail++; $display("FAIL reset[%0d]: scoreboard empty, want one entry", i);
      end else begin
        e = sb.pop_front();
        if ({bus.ce, bus.jump_misalign, bus.pc, bus.misalign_addr} !== {e.ce, e.mis, e.pc, e.ma}) begin
          n_fail++;
          $display("FAIL reset[%0d]: got ce=%b mis=%b pc=%h ma=%h, want ce=%b mis=%b pc=%h ma=%h",
                   i, bus.ce, bus.jump_misalign, bus.pc, bus.misalign_addr, e.ce, e.mis, e.pc, e.ma);
        end
        if (e.st >= 0) begin
          n_assert++;
          if (int'(dut.state_q) != e.st || int'(dut.pend_valid_q) != e.pv) begin
            n_fail++;
            $display("FAIL reset_state[%0d]: got st=%0d pv=%0d, want st=%0d pv=%0d",
                     i, int'(dut.state_q), int'(dut.pend_valid_q), e.st, e.pv);
          end
        end
      end
    end
  endtask

  task automatic test_stall();
    stim_t t[6];
    exp_t  e;
    t = '{
      '{1, 6'h01, 6'h00, 0, 32'h0, 0, 32'h0, 32'h10, 1, 0, 32'h0, -1, -1},
      '{1, 6'h01, 6'h00, 0, 32'h0, 0, 32'h0, 32'h10, 1, 0, 32'h0, -1, -1},
      '{1, 6'h01, 6'h00, 0, 32'h0, 0, 32'h0, 32'h10, 1, 0, 32'h0, 1, 0},
      '{1, 6'h00, 6'h00, 0, 32'h0, 0, 32'h0, 32'h14, 1, 0, 32'h0, -1, -1},
      '{1, 6'h3E, 6'h00, 0, 32'h0, 0, 32'h0, 32'h18, 1, 0, 32'h0, -1, -1},
      '{1, 6'h00, 6'h01, 0, 32'h0, 0, 32'h0, 32'h1C, 1, 0, 32'h0, -1, -1}
    };
    foreach (t[i]) begin
      drive(t[i]);
      n_assert++;
      if (sb.size() == 0) begin
        n_fail++; $display("FAIL stall[%0d]: scoreboard empty, want one entry", i);
      end else begin
        e = sb.pop_front();
        if ({bus.ce, bus.jump_misalign, bus.pc, bus.misalign_addr} !== {e.ce, e.mis, e.pc, e.ma}) begin
          n_fail++;
          $display("FAIL stall[%0d]: got ce=%b mis=%b pc=%h ma=%h, want ce=%b mis=%b pc=%h ma=%h",
                   i, bus.ce, bus.jump_misalign, bus.pc, bus.misalign_addr, e.ce, e.mis, e.pc, e.ma);
        end
        if (e.st >= 0) begin
          n_assert++;
          if (int'(dut.state_q) != e.st || int'(dut.pend_valid_q) != e.pv) begin
            n_fail++;
            $display("FAIL stall_state[%0d]: got st=%0d pv=%0d, want st=%0d pv=%0d",
                     i, int'(dut.state_q), int'(dut.pend_valid_q), e.st, e.pv);
          end
        end
      end
    end
  endtask

  task automatic test_jump_stall();
    stim_t t[4];
    exp_t  e;
    t = '{
      '{1, 6'h01, 6'h00, 1, 32'h80, 0, 32'h0, 32'h1C, 1, 0, 32'h0, 2, 1},
      '{1, 6'h01, 6'h00, 0, 32'h0,  0, 32'h0, 32'h1C, 1, 0, 32'h0, 2, 1},
      '{1, 6'h00, 6'h00, 0, 32'h0,  0, 32'h0, 32'h80, 1, 0, 32'h0, 1, 0},
      '{1, 6'h00, 6'h00, 0, 32'h0,  0, 32'h0, 32'h84, 1, 0, 32'h0, -1, -1}
    };
    foreach (t[i]) begin
      drive(t[i]);
      n_assert++;
      if (sb.size() == 0) begin
        n_fail++; $display("FAIL jump_stall[%0d]: scoreboard empty, want one entry", i);
      end else begin
        e = sb.pop_front();
        if ({bus.ce, bus.jump_misalign, bus.pc, bus.misalign_addr} !== {e.ce, e.mis, e.pc, e.ma}) begin
          n_fail++;
          $display("FAIL jump_stall[%0d]: got ce=%b mis=%b pc=%h ma=%h, want ce=%b mis=%b pc=%h ma=%h",
                   i, bus.ce, bus.jump_misalign, bus.pc, bus.misalign_addr, e.ce, e.mis, e.pc, e.ma);
        end
        if (e.st >= 0) begin
          n_assert++;
          if (int'(dut.state_q) != e.st || int'(dut.pend_valid_q) != e.pv) begin
            n_fail++;
            $display("FAIL jump_stall_state[%0d]: got st=%0d pv=%0d, want st=%0d pv=%0d",
                     i, int'(dut.state_q), int'(dut.pend_valid_q), e.st, e.pv);
          end
        end
      end
    end
  endtask

  task automatic test_trap_vs_jump();
    stim_t t[6];
    exp_t  e;
    t = '{
      '{1, 6'h00, 6'h00, 1, 32'h80,  1, 32'h200, 32'h200, 1, 0, 32'h0, 1, 0},
      '{1, 6'h01, 6'h00, 1, 32'h300, 0, 32'h0,   32'h200, 1, 0, 32'h0, 2, 1},
      '{1, 6'h01, 6'h01, 0, 32'h0,   1, 32'h400, 32'h400, 1, 0, 32'h0, 1, 0},
      '{1, 6'h00, 6'h00, 0, 32'h0,   0, 32'h0,   32'h404, 1, 0, 32'h0, -1, -1},
      '{1, 6'h00, 6'h00, 1, 32'h83,  1, 32'h500, 32'h500, 1, 0, 32'h0, 1, 0},
      '{1, 6'h00, 6'h00, 0, 32'h0,   0, 32'h0,   32'h504, 1, 0, 32'h0, -1, -1}
    };
    foreach (t[i]) begin
      drive(t[i]);
      n_assert++;
      if (sb.size() == 0) begin
        n_fail++; $display("FAIL trap_jump[%0d]: scoreboard empty, want one entry", i);
      end else begin
        e = sb.pop_front();
        if ({bus.ce, bus.jump_misalign, bus.pc, bus.misalign_addr} !== {e.ce, e.mis, e.pc, e.ma}) begin
          n_fail++;
          $display("FAIL trap_jump[%0d]: got ce=%b mis=%b pc=%h ma=%h, want ce=%b mis=%b pc=%h ma=%h",
                   i, bus.ce, bus.jump_misalign, bus.pc, bus.misalign_addr, e.ce, e.mis, e.pc, e.ma);
        end
        if (e.st >= 0) begin
          n_assert++;
          if (int'(dut.state_q) != e.st || int'(dut.pend_valid_q) != e.pv) begin
            n_fail++;
            $display("FAIL trap_jump_state[%0d]: got st=%0d pv=%0d, want st=%0d pv=%0d",
                     i, int'(dut.state_q), int'(dut.pend_valid_q), e.st, e.pv);
          end
        end
      end
    end
  endtask

  task automatic test_misalign();
    stim_t t[4];
    exp_t  e;
    t = '{
      '{1, 6'h00, 6'h00, 1, 32'h82,  0, 32'h0, 32'h508, 1, 1, 32'h82,  1, 0},
      '{1, 6'h00, 6'h00, 0, 32'h0,   0, 32'h0, 32'h50C, 1, 0, 32'h82,  -1, -1},
      '{1, 6'h01, 6'h00, 1, 32'h4A1, 0, 32'h0, 32'h50C, 1, 1, 32'h4A1, 1, 0},
      '{1, 6'h00, 6'h00, 0, 32'h0,   0, 32'h0, 32'h510, 1, 0, 32'h4A1, -1, -1}
    };
    foreach (t[i]) begin
      drive(t[i]);
      n_assert++;
      if (sb.size() == 0) begin
        n_fail++; $display("FAIL misalign[%0d]: scoreboard empty, want one entry", i);
      end else begin
        e = sb.pop_front();
        if ({bus.ce, bus.jump_misalign, bus.pc, bus.misalign_addr} !== {e.ce, e.mis, e.pc, e.ma}) begin
          n_fail++;
          $display("FAIL misalign[%0d]: got ce=%b mis=%b pc=%h ma=%h, want ce=%b mis=%b pc=%h ma=%h",
                   i, bus.ce, bus.jump_misalign, bus.pc, bus.misalign_addr, e.ce, e.mis, e.pc, e.ma);
        end
        if (e.st >= 0) begin
          n_assert++;
          if (int'(dut.state_q) != e.st || int'(dut.pend_valid_q) != e.pv) begin
            n_fail++;
            $display("FAIL misalign_state[%0d]: got st=%0d pv=%0d, want st=%0d pv=%0d",
                     i, int'(dut.state_q), int'(dut.pend_valid_q), e.st, e.pv);
          end
        end
      end
    end
  endtask

  task automatic test_flush_pending();
    stim_t t[7];
    exp_t  e;
    t = '{
      '{1, 6'h01, 6'h00, 1, 32'h100, 0, 32'h0, 32'h510, 1, 0, 32'h4A1, 2, 1},
      '{1, 6'h01, 6'h00, 1, 32'h180, 0, 32'h0, 32'h510, 1, 0, 32'h4A1, 2, 1},
      '{1, 6'h01, 6'h01, 0, 32'h0,   0, 32'h0, 32'h180, 1, 0, 32'h4A1, 1, 0},
      '{1, 6'h00, 6'h00, 0, 32'h0,   0, 32'h0, 32'h184, 1, 0, 32'h4A1, -1, -1},
      '{1, 6'h00, 6'h01, 1, 32'h500, 0, 32'h0, 32'h500, 1, 0, 32'h4A1, -1, -1},
      '{1, 6'h01, 6'h01, 1, 32'h600, 0, 32'h0, 32'h600, 1, 0, 32'h4A1, 1, 0},
      '{1, 6'h00, 6'h00, 0, 32'h0,   0, 32'h0, 32'h604, 1, 0, 32'h4A1, -1, -1}
    };
    foreach (t[i]) begin
      drive(t[i]);
      n_assert++;
      if (sb.size() == 0) begin
        n_fail++; $display("FAIL flush_pend[%0d]: scoreboard empty, want one entry", i);
      end else begin
        e = sb.pop_front();
        if ({bus.ce, bus.jump_misalign, bus.pc, bus.misalign_addr} !== {e.ce, e.mis, e.pc, e.ma}) begin
          n_fail++;
          $display("FAIL flush_pend[%0d]: got ce=%b mis=%b pc=%h ma=%h, want ce=%b mis=%b pc=%h ma=%h",
                   i, bus.ce, bus.jump_misalign, bus.pc, bus.misalign_addr, e.ce, e.mis, e.pc, e.ma);
        end
        if (e.st >= 0) begin
          n_assert++;
          if (int'(dut.state_q) != e.st || int'(dut.pend_valid_q) != e.pv) begin
            n_fail++;
            $display("FAIL flush_pend_state[%0d]: got st=%0d pv=%0d, want st=%0d pv=%0d",
                     i, int'(dut.state_q), int'(dut.pend_valid_q), e.st, e.pv);
          end
        end
      end
    end
  endtask

  task automatic test_wrap();
    stim_t t[5];
    exp_t  e;
    t = '{
      '{1, 6'h00, 6'h00, 0, 32'h0,   1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1, 0, 32'h4A1, -1, -1},
      '{1, 6'h00, 6'h00, 0, 32'h0,   0, 32'h0,         32'hFFFF_FFFC, 1, 0, 32'h4A1, -1, -1},
      '{1, 6'h00, 6'h00, 0, 32'h0,   0, 32'h0,         32'h0000_0000, 1, 0, 32'h4A1, -1, -1},
      '{1, 6'h00, 6'h00, 0, 32'h0,   0, 32'h0,         32'h0000_0004, 1, 0, 32'h4A1, -1, -1},
      '{1, 6'h00, 6'h00, 1, 32'h700, 0, 32'h0,         32'h0000_0700, 1, 0, 32'h4A1, 1, 0}
    };
    foreach (t[i]) begin
      drive(t[i]);
      n_assert++;
      if (sb.size() == 0) begin
        n_fail++; $display("FAIL wrap[%0d]: scoreboard empty, want one entry", i);
      end else begin
        e = sb.pop_front();
        if ({bus.ce, bus.jump_misalign, bus.pc, bus.misalign_addr} !== {e.ce, e.mis, e.pc, e.ma}) begin
          n_fail++;
          $display("FAIL wrap[%0d]: got ce=%b mis=%b pc=%h ma=%h, want ce=%b mis=%b pc=%h ma=%h",
                   i, bus.ce, bus.jump_misalign, bus.pc, bus.misalign_addr, e.ce, e.mis, e.pc, e.ma);
        end
        if (e.st >= 0) begin
          n_assert++;
          if (int'(dut.state_q) != e.st || int'(dut.pend_valid_q) != e.pv) begin
            n_fail++;
            $display("FAIL wrap_state[%0d]: got st=%0d pv=%0d, want st=%0d pv=%0d",
                     i, int'(dut.state_q), int'(dut.pend_valid_q), e.st, e.pv);
          end
        end
      end
    end
  endtask

  task automatic test_reset_in_hold();
    stim_t t[5];
    exp_t  e;
    t = '{
      '{1, 6'h01, 6'h00, 1, 32'h800, 0, 32'h0, 32'h700, 1, 0, 32'h4A1, 2, 1},
      '{0, 6'h01, 6'h00, 0, 32'h0,   0, 32'h0, 32'h0,   0, 0, 32'h0,   0, 0},
      '{1, 6'h00, 6'h00, 0, 32'h0,   0, 32'h0, 32'h0,   1, 0, 32'h0,   1, 0},
      '{1, 6'h00, 6'h00, 0, 32'h0,   0, 32'h0, 32'h4,   1, 0, 32'h0,   1, 0},
      '{1, 6'h00, 6'h00, 0, 32'h0,   0, 32'h0, 32'h8,   1, 0, 32'h0,   -1, -1}
    };
    foreach (t[i]) begin
      drive(t[i]);
      n_assert++;
      if (sb.size() == 0) begin
        n_fail++; $display("FAIL rst_hold[%0d]: scoreboard empty, want one entry", i);
      end else begin
        e = sb.pop_front();
        if ({bus.ce, bus.jump_misalign, bus.pc, bus.misalign_addr} !== {e.ce, e.mis, e.pc, e.ma}) begin
          n_fail++;
          $display("FAIL rst_hold[%0d]: got ce=%b mis=%b pc=%h ma=%h, want ce=%b mis=%b pc=%h ma=%h",
                   i, bus.ce, bus.jump_misalign, bus.pc, bus.misalign_addr, e.ce, e.mis, e.pc, e.ma);
        end
        if (e.st >= 0) begin
          n_assert++;
          if (int'(dut.state_q) != e.st || int'(dut.pend_valid_q) != e.pv) begin
            n_fail++;
            $display("FAIL rst_hold_state[%0d]: got st=%0d pv=%0d, want st=%0d pv=%0d",
                     i, int'(dut.state_q), int'(dut.pend_valid_q), e.st, e.pv);
          end
        end
      end
    end
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.stall     = '0;
    bus.flush     = '0;
    bus.jump_req  = 1'b0;
    bus.jump_addr = '0;
    bus.trap_req  = 1'b0;
    bus.trap_addr = '0;
    repeat (2) @(posedge clk);

    test_reset();
    test_stall();
    test_jump_stall();
    test_trap_vs_jump();
    test_misalign();
    test_flush_pending();
    test_wrap();
    test_reset_in_hold();

    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d leftover entries, want 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
